sim_jtag_vector_driver: RTL and testbench
=========================================

// Module: sim_jtag_vector_driver
// PURPOSE
//  Synthesizable, parametrised JTAG pin driver for simulation and emulation. It replaces per-tick host calls with vector commands.
//  A host-side agent (DPI bridge or transactor FIFO) pushes commands of up to VEC_W TMS/TDI bits. The block generates TCK with a
//  programmable half-period, shifts the bits out LSB-first, captures TDO on every TCK rising edge and returns the captured vector.
//  Sits between the host transactor and the DUT debug module's JTAG pins.
// PARAMETERS
//  VEC_W       32   max bits per command; also the width of the TMS/TDI/TDO vectors
//  LEN_W       6    width of the length fields; must hold VEC_W, i.e. >= $clog2(VEC_W+1)
//  TICK_DELAY  50   each TCK phase (low or high) lasts TICK_DELAY+1 clock cycles
//  LFSR_SEED   16'hACE1  seed of the fill LFSR used when TDO is undriven; must be non-zero
// PORTS
//  clock          in   1      sole clock
//  reset          in   1      asynchronous, active-low reset
//  enable         in   1      run gate; 0 freezes the active phase counter (pause)
//  init_done      in   1      DUT init complete; latched into a sticky flag
//  cmd_valid      in   1      command offered
//  cmd_ready      out  1      command accepted when valid&ready
//  cmd_len        in   LEN_W  number of TCK periods; values > VEC_W are clamped to VEC_W
//  cmd_tms        in   VEC_W  TMS bit per period, bit 0 first
//  cmd_tdi        in   VEC_W  TDI bit per period, bit 0 first
//  cmd_trst       in   1      1: hold TRSTn low for the whole command; TMS forced 1, TDI forced 0
//  cmd_capture    in   1      1: produce a response when the command completes
//  rsp_valid      out  1      response available
//  rsp_ready      in   1      response consumed when valid&ready
//  rsp_tdo        out  VEC_W  captured TDO; bit i from rising edge i; unused bits 0
//  rsp_len        out  LEN_W  clamped length of the completed command
//  jtag_TCK       out  1      JTAG clock
//  jtag_TMS       out  1      JTAG mode select
//  jtag_TDI       out  1      JTAG data in
//  jtag_TRSTn     out  1      JTAG reset, active-low
//  jtag_TDO_data  in   1      DUT TDO value
//  jtag_TDO_driven in  1      DUT TDO output enable
//  busy           out  1      1 in every state except IDLE
// BEHAVIOUR
//  Reset (asynchronous, reset=0), effective immediately:
//   - Pins: TCK=0, TMS=1, TDI=0, TRSTn=1.
//   - Handshake and data: cmd_ready=0, rsp_valid=0, rsp_tdo=0, rsp_len=0, busy=0.
//   - State: state=IDLE, sticky flag=0, LFSR=LFSR_SEED.
//   - A reset asserted mid-command abandons the command and any pending response.
//  Sticky flag: the registered sticky flag is set on init_done=1 and cleared only by reset.
//  Ready: cmd_ready = (state==IDLE) & enable & sticky. cmd_ready is a registered-state function, not a function of cmd_valid.
//  FSM states:
//   - IDLE, on accept with clamped len>0: latch the command, bit index=0, load phase counter=TICK_DELAY, go to LOW.
//     Drive TMS/TDI/TRSTn for bit 0 on the same edge.
//   - IDLE, on accept with len=0: if capture, go to RESP with rsp_tdo=0 and rsp_len=0, so rsp_valid is high next cycle.
//     Otherwise stay in IDLE. No TCK activity in either case.
//   - LOW: TCK=0. Counter decrements each cycle while enable=1.
//     At 0 with enable=1: TCK<=1, capture TDO into bit[index], reload the counter, go to HIGH.
//   - HIGH: TCK=1. At counter 0 with enable=1: TCK<=0.
//     If this was the last bit: go to RESP if capture, else IDLE. TMS returns to 1, TDI to 0, TRSTn to 1.
//     Otherwise: index+1, present the next TMS/TDI, reload the counter, go to LOW.
//   - RESP: rsp_valid=1 with rsp_tdo and rsp_len stable. Go to IDLE on rsp_ready. cmd_ready=0 while in RESP.
//  Timing: one TCK period = 2*(TICK_DELAY+1) cycles. A command of N bits lasts 2N(TICK_DELAY+1) cycles from accept to leaving HIGH.
//   TMS/TDI change only on the edge where TCK falls (or on accept), so the DUT sees TICK_DELAY+1 cycles of setup and hold.
//  TDO sampling: sample = TDO_driven ? TDO_data : lfsr[0].
//   - The LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every clock cycle while not in reset.
//  enable=0 mid-command: counter and all pins hold. enable=0 in IDLE only blocks accept. enable=0 in RESP has no effect.
//  Simultaneous events: in RESP, rsp_ready and a new cmd_valid in the same cycle -> the command is not accepted that cycle.
// TESTING
//  1. Release reset, init_done=0 -> cmd_ready stays 0. Pulse init_done for 1 cycle -> cmd_ready=1 from the next cycle and stays 1.
//  2. TICK_DELAY=2, len=5, tms=5'b10110, tdi=5'b01011, capture=1, TDO driven=1, data=1:
//     -> 5 TCK pulses, each 3 high / 3 low; rsp_tdo=0x1F, rsp_len=5; rsp_valid 30 cycles after accept.
//  3. TDO_driven=0, len=16 -> rsp_tdo matches a reference LFSR model sampled at each rising edge.
//  4. len=0 with capture=1 -> rsp_valid the next cycle, rsp_tdo=0, no TCK edge. len=40 with VEC_W=32 -> exactly 32 pulses, rsp_len=32.
//  5. Hold rsp_ready=0 for 20 cycles -> rsp stable, cmd_ready=0, busy=1. Raise rsp_ready -> IDLE, then cmd_ready=1.
//  6. enable=0 for 10 cycles mid-HIGH -> that high phase lasts TICK_DELAY+11 cycles.
//     reset=0 mid-HIGH -> TCK=0, TRSTn=1, rsp_valid=0 with no clock edge.
//  7. cmd_trst=1, len=4 -> TRSTn low for all 4 periods, TMS=1, TDI=0; TRSTn returns to 1 when the command completes.

Source files
------------

// File: rtl/sim_jtag_vector_driver.sv
// Vector-command JTAG pin driver: shifts up to VEC_W TMS/TDI bits LSB-first on a generated TCK
// and returns the TDO bits captured on each TCK rising edge.
module sim_jtag_vector_driver #(
    parameter int          VEC_W      = 32,
    parameter int          LEN_W      = 6,
    parameter int          TICK_DELAY = 50,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             init_done,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [VEC_W-1:0] cmd_tms,
    input  logic [VEC_W-1:0] cmd_tdi,
    input  logic             cmd_trst,
    input  logic             cmd_capture,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [VEC_W-1:0] rsp_tdo,
    output logic [LEN_W-1:0] rsp_len,
    output logic             jtag_TCK,
    output logic             jtag_TMS,
    output logic             jtag_TDI,
    output logic             jtag_TRSTn,
    input  logic             jtag_TDO_data,
    input  logic             jtag_TDO_driven,
    output logic             busy
);

    localparam int IDX_W = (VEC_W > 1) ? $clog2(VEC_W) : 1;
    localparam int CNT_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
    localparam logic [LEN_W-1:0] LP_VEC_LEN = LEN_W'(VEC_W);
    localparam logic [CNT_W-1:0] LP_TICK    = CNT_W'(TICK_DELAY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_sticky;
    logic [15:0]        r_lfsr;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [VEC_W-1:0]   r_tms;
    logic [VEC_W-1:0]   r_tdi;
    logic [VEC_W-1:0]   r_tdo;
    logic               r_trst;
    logic               r_capture;
    logic               r_rsp_valid;
    logic               r_tck;
    logic               r_tms_o;
    logic               r_tdi_o;
    logic               r_trstn;

    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_ready;
    logic               w_accept;
    logic               w_sample;
    logic               w_last;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_lfsr_fb;

    assign w_len_clamped = (cmd_len > LP_VEC_LEN) ? LP_VEC_LEN : cmd_len;
    assign w_ready       = (r_state == S_IDLE) & enable & r_sticky;
    assign w_accept      = cmd_valid & w_ready;
    assign w_sample      = jtag_TDO_driven ? jtag_TDO_data : r_lfsr[0];
    assign w_last        = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    assign w_next_idx    = r_idx + IDX_W'(1);
    assign w_lfsr_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    assign cmd_ready  = w_ready;
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_tdo    = r_tdo;
    assign rsp_len    = r_len;
    assign jtag_TCK   = r_tck;
    assign jtag_TMS   = r_tms_o;
    assign jtag_TDI   = r_tdi_o;
    assign jtag_TRSTn = r_trstn;

    // Fill source for an undriven TDO; free-runs so successive captures see fresh values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_tms       <= '0;
            r_tdi       <= '0;
            r_tdo       <= '0;
            r_trst      <= 1'b0;
            r_capture   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_tck       <= 1'b0;
            r_tms_o     <= 1'b1;
            r_tdi_o     <= 1'b0;
            r_trstn     <= 1'b1;
        end else begin
            if (init_done) begin
                r_sticky <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tdo <= '0;
                        r_len <= w_len_clamped;
                        if (w_len_clamped != '0) begin
                            r_tms     <= cmd_tms;
                            r_tdi     <= cmd_tdi;
                            r_trst    <= cmd_trst;
                            r_capture <= cmd_capture;
                            r_idx     <= '0;
                            r_cnt     <= LP_TICK;
                            r_tms_o   <= cmd_trst | cmd_tms[0];
                            r_tdi_o   <= ~cmd_trst & cmd_tdi[0];
                            r_trstn   <= ~cmd_trst;
                            r_state   <= S_LOW;
                        end else if (cmd_capture) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_LOW: begin
                    if (enable) begin
                        if (r_cnt == '0) begin
                            r_tck        <= 1'b1;
                            r_tdo[r_idx] <= w_sample;
                            r_cnt        <= LP_TICK;
                            r_state      <= S_HIGH;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_HIGH: begin
                    if (enable) begin
                        if (r_cnt == '0) begin
                            r_tck <= 1'b0;
                            // TMS/TDI only move on the falling TCK edge, giving a full phase of setup and hold.
                            if (w_last) begin
                                r_tms_o <= 1'b1;
                                r_tdi_o <= 1'b0;
                                r_trstn <= 1'b1;
                                if (r_capture) begin
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= S_RESP;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_idx   <= w_next_idx;
                                r_tms_o <= r_trst | r_tms[w_next_idx];
                                r_tdi_o <= ~r_trst & r_tdi[w_next_idx];
                                r_cnt   <= LP_TICK;
                                r_state <= S_LOW;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_jtag_vector_driver.sv
// Randomised bench for sim_jtag_vector_driver: a timeline model (elapsed TCK-active cycles per command)
// predicts every output each cycle, plus directed scenarios with hand-computed expectations.
module tb_sim_jtag_vector_driver;

    localparam int VW  = 32;
    localparam int LW  = 6;
    localparam int TD  = 2;
    localparam int PER = 2 * (TD + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic          init_done = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [VW-1:0] cmd_tms = '0;
    logic [VW-1:0] cmd_tdi = '0;
    logic          cmd_trst = 1'b0;
    logic          cmd_capture = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [VW-1:0] rsp_tdo;
    logic [LW-1:0] rsp_len;
    logic          jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic          jtag_TDO_data = 1'b0;
    logic          jtag_TDO_driven = 1'b0;
    logic          busy;

    sim_jtag_vector_driver #(
        .VEC_W(VW), .LEN_W(LW), .TICK_DELAY(TD), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi), .cmd_trst(cmd_trst), .cmd_capture(cmd_capture),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo), .rsp_len(rsp_len),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
        .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int  enMode = 0;
    int  rdyMode = 0;
    int  tdoMode = 0;

    bit          mSticky, mActive, mResp, mTrst, mCap, rdyPre;
    int          mK, mN, mRspLen, n, p, ph;
    logic [VW-1:0] mTms, mTdi, mTdo, mRspTdo;
    logic [15:0] mLfsr = 16'hACE1;
    logic        eTck, eTms, eTdi, eTrstn, eBusy, eValid, eReady;

    int  cyc = 0;
    int  lastAcceptCyc = 0;
    int  rspRiseCyc = 0;
    int  tckRises = 0;
    int  curHigh = 0;
    int  maxHigh = 0;
    logic prevTck = 1'b0;
    logic prevValid = 1'b0;

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (enMode == 1) enable = ($urandom_range(0, 7) != 0);
        if (rdyMode == 1) rsp_ready = 1'($urandom_range(0, 1));
        if (tdoMode == 1) begin
            jtag_TDO_driven = 1'($urandom_range(0, 1));
            jtag_TDO_data   = 1'($urandom_range(0, 1));
        end
    end

    // Model advances on the clock edge from the pre-edge inputs, then every output is compared.
    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            mSticky = 0; mActive = 0; mResp = 0; mK = 0; mN = 0;
            mRspTdo = '0; mRspLen = 0; mLfsr = 16'hACE1;
        end else begin
            rdyPre = !mActive && !mResp && enable && mSticky;
            if (mActive) begin
                if (enable) begin
                    if (mK % PER == TD)
                        mTdo[mK / PER] = jtag_TDO_driven ? jtag_TDO_data : mLfsr[0];
                    mK++;
                    if (mK == mN * PER) begin
                        mActive = 0;
                        if (mCap) begin
                            mResp = 1; mRspTdo = mTdo; mRspLen = mN;
                        end
                    end
                end
            end else if (mResp) begin
                if (rsp_ready) mResp = 0;
            end else if (cmd_valid && rdyPre) begin
                n = (cmd_len > VW) ? VW : int'(cmd_len);
                lastAcceptCyc = cyc;
                if (n > 0) begin
                    mActive = 1; mK = 0; mN = n; mTms = cmd_tms; mTdi = cmd_tdi;
                    mTrst = cmd_trst; mCap = cmd_capture; mTdo = '0;
                end else if (cmd_capture) begin
                    mResp = 1; mRspTdo = '0; mRspLen = 0;
                end
            end
            if (init_done) mSticky = 1;
            mLfsr = lfsrStep(mLfsr);
        end
        #1;
        if (mActive) begin
            p = mK / PER; ph = mK % PER;
            eTck = (ph > TD); eTms = mTrst ? 1'b1 : mTms[p];
            eTdi = mTrst ? 1'b0 : mTdi[p]; eTrstn = !mTrst;
        end else begin
            eTck = 0; eTms = 1; eTdi = 0; eTrstn = 1;
        end
        eBusy = mActive || mResp; eValid = mResp; eReady = !eBusy && enable && mSticky;
        checkOutput("pins{ready,busy,valid,tck,tms,tdi,trstn}",
                    {cmd_ready, busy, rsp_valid, jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn},
                    {eReady, eBusy, eValid, eTck, eTms, eTdi, eTrstn});
        if (mResp) begin
            checkOutput("rsp_tdo", rsp_tdo, mRspTdo);
            checkOutput("rsp_len", rsp_len, mRspLen);
        end
        if (jtag_TCK && !prevTck) tckRises++;
        if (jtag_TCK) curHigh++;
        else if (prevTck) begin
            if (curHigh > maxHigh) maxHigh = curHigh;
            curHigh = 0;
        end
        if (rsp_valid && !prevValid) rspRiseCyc = cyc;
        prevTck = jtag_TCK;
        prevValid = rsp_valid;
    end

    task automatic applyStimulus(input int len, input logic [VW-1:0] tms, input logic [VW-1:0] tdi,
                                 input logic trst, input logic cap);
        int  budget;
        bit  hs, accepted;
        @(negedge clock);
        cmd_len = LW'(len); cmd_tms = tms; cmd_tdi = tdi; cmd_trst = trst; cmd_capture = cap;
        cmd_valid = 1'b1;
        budget = 0; accepted = 0;
        while (!accepted && budget < 3000) begin
            #1 hs = cmd_ready;
            @(posedge clock);
            if (hs) accepted = 1;
            else begin
                @(negedge clock);
                budget++;
            end
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input int budget);
        int k = 0;
        while (!rsp_valid && k < budget) begin
            @(negedge clock); k++;
        end
        checkOutput("rsp_wait", rsp_valid, 1);
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while ((busy || rsp_valid) && k < budget) begin
            @(negedge clock); k++;
        end
        checkOutput("idle_wait", {busy, rsp_valid}, 2'b00);
    endtask

    task automatic waitTckHigh(input int budget);
        int k = 0;
        while (!jtag_TCK && k < budget) begin
            @(negedge clock); k++;
        end
        checkOutput("tck_wait", jtag_TCK, 1);
    endtask

    int r0;

    initial begin
        checkOutput("lfsr_model_pin", lfsrStep(mLfsr), 16'h5670);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("ready_before_init", cmd_ready, 0);
        init_done = 1'b1;
        @(negedge clock);
        init_done = 1'b0;
        checkOutput("ready_after_init", cmd_ready, 1);
        repeat (5) @(negedge clock);
        checkOutput("ready_sticky", cmd_ready, 1);

        // Basic 5-bit capture with TDO driven high
        jtag_TDO_driven = 1'b1; jtag_TDO_data = 1'b1;
        r0 = tckRises; maxHigh = 0;
        applyStimulus(5, 32'b10110, 32'b01011, 1'b0, 1'b1);
        waitRsp(100);
        checkOutput("basic_tdo", rsp_tdo, 32'h1F);
        checkOutput("basic_len", rsp_len, 5);
        checkOutput("basic_latency", rspRiseCyc - lastAcceptCyc, 30);
        checkOutput("basic_pulses", tckRises - r0, 5);
        checkOutput("basic_high_len", maxHigh, 3);

        // Response held back by the consumer
        repeat (20) @(negedge clock);
        checkOutput("held_state", {rsp_valid, cmd_ready, busy}, 3'b101);
        checkOutput("held_tdo", rsp_tdo, 32'h1F);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        checkOutput("ready_after_resp", cmd_ready, 1);

        // Undriven TDO captures the fill LFSR
        jtag_TDO_driven = 1'b0;
        applyStimulus(16, $urandom, $urandom, 1'b0, 1'b1);
        waitRsp(300);
        checkOutput("lfsr_len", rsp_len, 16);
        rsp_ready = 1'b1;
        waitIdle(20);
        rsp_ready = 1'b0;

        // Zero-length and over-length commands
        r0 = tckRises;
        applyStimulus(0, $urandom, $urandom, 1'b0, 1'b1);
        checkOutput("zero_state", {rsp_valid, rsp_tdo, rsp_len}, {1'b1, 32'h0, 6'd0});
        checkOutput("zero_pulses", tckRises - r0, 0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        tdoMode = 1;
        r0 = tckRises;
        applyStimulus(40, $urandom, $urandom, 1'b0, 1'b1);
        waitRsp(600);
        checkOutput("clamp_len", rsp_len, 32);
        checkOutput("clamp_pulses", tckRises - r0, 32);
        rsp_ready = 1'b1;
        waitIdle(20);
        rsp_ready = 1'b0;

        // Pause in the middle of a high phase
        maxHigh = 0;
        applyStimulus(3, $urandom, $urandom, 1'b0, 1'b0);
        waitTckHigh(50);
        enable = 1'b0;
        repeat (10) @(negedge clock);
        enable = 1'b1;
        waitIdle(200);
        checkOutput("pause_high_len", maxHigh, TD + 11);

        // Asynchronous reset in the middle of a high phase
        applyStimulus(4, $urandom, $urandom, 1'b0, 1'b1);
        waitTckHigh(50);
        reset = 1'b0;
        #1;
        checkOutput("async_reset", {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, rsp_valid, busy, cmd_ready},
                    7'b0101000);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        init_done = 1'b1;
        @(negedge clock);
        init_done = 1'b0;

        // Test reset command
        applyStimulus(4, $urandom, $urandom, 1'b1, 1'b0);
        waitTckHigh(50);
        checkOutput("trst_pins", {jtag_TRSTn, jtag_TMS, jtag_TDI}, 3'b010);
        waitIdle(200);
        checkOutput("trst_release", jtag_TRSTn, 1);

        // Randomised traffic
        enMode = 1; rdyMode = 1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus($urandom_range(0, 40), $urandom, $urandom,
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            waitIdle(3000);
        end
        enMode = 0; rdyMode = 0; tdoMode = 0;
        enable = 1'b1;
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
